// File: rtl/seg7_pkg.sv
// Shared character codes, segment patterns and the 5-bit to 7-segment decode
// used by the front-panel display blocks.
package seg7_pkg;

  typedef logic [4:0] char_code_t;
  typedef logic [6:0] seg_pattern_t;

  localparam char_code_t CH_BLANK = 5'h10;
  localparam char_code_t CH_C     = 5'h11;
  localparam char_code_t CH_E     = 5'h12;
  localparam char_code_t CH_R     = 5'h13;
  localparam char_code_t CH_S     = 5'h14;
  localparam char_code_t CH_P     = 5'h15;
  localparam char_code_t CH_DASH  = 5'h16;

  // Patterns are {g,f,e,d,c,b,a}, active high.
  localparam seg_pattern_t SEG_0     = 7'b0111111;
  localparam seg_pattern_t SEG_1     = 7'b0000110;
  localparam seg_pattern_t SEG_2     = 7'b1011011;
  localparam seg_pattern_t SEG_3     = 7'b1001111;
  localparam seg_pattern_t SEG_4     = 7'b1100110;
  localparam seg_pattern_t SEG_5     = 7'b1101101;
  localparam seg_pattern_t SEG_6     = 7'b1111101;
  localparam seg_pattern_t SEG_7     = 7'b0000111;
  localparam seg_pattern_t SEG_8     = 7'b1111111;
  localparam seg_pattern_t SEG_9     = 7'b1101111;
  localparam seg_pattern_t SEG_HEX_A = 7'b1110111;
  localparam seg_pattern_t SEG_HEX_B = 7'b1111100;
  localparam seg_pattern_t SEG_HEX_C = 7'b0111001;
  localparam seg_pattern_t SEG_HEX_D = 7'b1011110;
  localparam seg_pattern_t SEG_HEX_E = 7'b1111001;
  localparam seg_pattern_t SEG_HEX_F = 7'b1110001;
  localparam seg_pattern_t SEG_BLANK = 7'b0000000;
  localparam seg_pattern_t SEG_C     = 7'b0111001;
  localparam seg_pattern_t SEG_E     = 7'b1111001;
  localparam seg_pattern_t SEG_R     = 7'b1010000;
  localparam seg_pattern_t SEG_S     = 7'b1101101;
  localparam seg_pattern_t SEG_P     = 7'b1110011;
  localparam seg_pattern_t SEG_DASH  = 7'b1000000;

  function automatic seg_pattern_t decode_char(input char_code_t code);
    seg_pattern_t pat;
    pat = SEG_BLANK;
    case (code)
      5'h00:   pat = SEG_0;
      5'h01:   pat = SEG_1;
      5'h02:   pat = SEG_2;
      5'h03:   pat = SEG_3;
      5'h04:   pat = SEG_4;
      5'h05:   pat = SEG_5;
      5'h06:   pat = SEG_6;
      5'h07:   pat = SEG_7;
      5'h08:   pat = SEG_8;
      5'h09:   pat = SEG_9;
      5'h0A:   pat = SEG_HEX_A;
      5'h0B:   pat = SEG_HEX_B;
      5'h0C:   pat = SEG_HEX_C;
      5'h0D:   pat = SEG_HEX_D;
      5'h0E:   pat = SEG_HEX_E;
      5'h0F:   pat = SEG_HEX_F;
      CH_C:    pat = SEG_C;
      CH_E:    pat = SEG_E;
      CH_R:    pat = SEG_R;
      CH_S:    pat = SEG_S;
      CH_P:    pat = SEG_P;
      CH_DASH: pat = SEG_DASH;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_char_decoder.sv
// Combinational 5-bit character code to 7-segment pattern decoder,
// shared with other front-panel blocks.
module seg7_char_decoder
  import seg7_pkg::*;
(
  input  char_code_t   i_code,
  output seg_pattern_t o_seg
);

  assign o_seg = decode_char(i_code);

endmodule

// File: rtl/seg7_msg_scanner.sv
// Time-multiplexed N-digit 7-segment message driver with double-buffered,
// frame-aligned message updates. Define SEG7_BLINK_EN to build whole-display blinking.
module seg7_msg_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [5*NUM_DIGITS-1:0] msg_data,
  input  logic                    msg_valid,
  output logic                    msg_ready,
  input  logic                    blink,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_prescale;
  logic [IW-1:0]         r_index;
  char_code_t            r_active [NUM_DIGITS];
  char_code_t            r_shadow [NUM_DIGITS];
  logic                  r_pending;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_start;

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_transfer;
  char_code_t            w_cur_code;
  seg_pattern_t          w_cur_seg;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_show;
  logic                  w_blink_off;

  assign w_tick      = (r_prescale == PS_LAST);
  assign w_frame_end = w_tick && (r_index == IDX_LAST);
  assign msg_ready   = ~r_pending;
  assign w_transfer  = msg_valid && ~r_pending;
  assign w_cur_code  = r_active[r_index];
  assign w_onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_index;
  assign w_show      = (r_prescale >= PS_BLANK) && ~w_blink_off;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_index    <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
      r_index    <= (r_index == IDX_LAST) ? '0 : r_index + 1'b1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // A transfer is only possible with pending clear, so it never collides with a commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_active[i] <= CH_BLANK;
        r_shadow[i] <= CH_BLANK;
      end
      r_pending <= 1'b0;
    end else begin
      if (w_frame_end && r_pending) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_pending <= 1'b0;
      end
      if (w_transfer) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          r_shadow[i] <= msg_data[5*i +: 5];
        end
        r_pending <= 1'b1;
      end
    end
  end

  seg7_char_decoder u_decoder (
    .i_code (w_cur_code),
    .o_seg  (w_cur_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_frame_cnt;
  logic          r_phase_on;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FC_LAST) begin
        r_frame_cnt <= '0;
        r_phase_on  <= ~r_phase_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_blink_off = blink & ~r_phase_on;
`else
  assign w_blink_off = blink & 1'b0;
`endif

  // Only the digit enables are blanked; seg stays valid for the whole slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_seg         <= '0;
      r_digit_en    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_cur_seg;
      r_digit_en    <= w_show ? w_onehot : '0;
      r_frame_start <= w_frame_end;
    end
  end

  assign seg         = r_seg;
  assign digit_en    = r_digit_en;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_msg_scanner.sv
// Directed self-checking bench for seg7_msg_scanner (NUM_DIGITS=4, PRESCALE=4,
// BLANK_CYCLES=1, BLINK_FRAMES=2); blink expectations follow SEG7_BLINK_EN.
module tb_seg7_msg_scanner;

  logic        clock;
  logic        reset_n;
  logic [19:0] msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic        blink;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        frame_start;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

`ifdef SEG7_BLINK_EN
  localparam logic [3:0] EN_BLINK_D0 = 4'b0000;
  localparam logic [3:0] EN_BLINK_D3 = 4'b0000;
`else
  localparam logic [3:0] EN_BLINK_D0 = 4'b0001;
  localparam logic [3:0] EN_BLINK_D3 = 4'b1000;
`endif

  seg7_msg_scanner #(
    .NUM_DIGITS   (4),
    .PRESCALE     (4),
    .BLANK_CYCLES (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .msg_data    (msg_data),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .blink       (blink),
    .seg         (seg),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic checkScan(input string tag, input logic [6:0] expSeg, input logic [3:0] expEn);
    checkOutput({tag, ".seg"}, {1'b0, seg}, {1'b0, expSeg});
    checkOutput({tag, ".en"}, {4'b0, digit_en}, {4'b0, expEn});
  endtask

  task automatic applyStimulus(input logic valid, input logic [19:0] data);
    msg_valid = valid;
    msg_data  = data;
  endtask

  // Advance to 1 time unit after rising edge n (edges counted from reset release).
  task automatic stepTo(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic pulseReset(input string tag);
    reset_n = 1'b0;
    #1;
    checkOutput({tag, ".seg"}, {1'b0, seg}, 8'h00);
    checkOutput({tag, ".en"}, {4'b0, digit_en}, 8'h00);
    checkOutput({tag, ".fs"}, {7'b0, frame_start}, 8'h00);
    checkOutput({tag, ".ready"}, {7'b0, msg_ready}, 8'h01);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    reset_n = 1'b1;
    blink   = 1'b0;
    applyStimulus(1'b0, 20'h0);
    #2;
    pulseReset("rst0");

    // Blank message scanning after reset
    stepTo(1);  checkScan("scan_e1", 7'b0000000, 4'b0000);
    stepTo(2);  checkScan("scan_e2", 7'b0000000, 4'b0001);
    stepTo(5);  checkScan("scan_e5", 7'b0000000, 4'b0000);
    stepTo(6);  checkScan("scan_e6", 7'b0000000, 4'b0010);
    stepTo(10); checkScan("scan_e10", 7'b0000000, 4'b0100);
    stepTo(14); checkScan("scan_e14", 7'b0000000, 4'b1000);
    stepTo(15); checkOutput("fs_e15", {7'b0, frame_start}, 8'h00);
    stepTo(16); checkOutput("fs_e16", {7'b0, frame_start}, 8'h01);
    stepTo(17); checkOutput("fs_e17", {7'b0, frame_start}, 8'h00);

    // Load 'C','E','0',blank mid-frame
    stepTo(18); applyStimulus(1'b1, {5'h10, 5'h00, 5'h12, 5'h11});
    stepTo(19); checkOutput("ld1_ready_e19", {7'b0, msg_ready}, 8'h00);
    applyStimulus(1'b0, 20'h0);
    stepTo(22); checkScan("ld1_old_d1", 7'b0000000, 4'b0010);
    stepTo(26); checkScan("ld1_old_d2", 7'b0000000, 4'b0100);
    stepTo(31); checkOutput("ld1_ready_e31", {7'b0, msg_ready}, 8'h00);
    stepTo(32); checkOutput("ld1_ready_e32", {7'b0, msg_ready}, 8'h01);
    checkOutput("ld1_fs_e32", {7'b0, frame_start}, 8'h01);
    stepTo(33); checkScan("ld1_blank_slot", 7'b0111001, 4'b0000);
    stepTo(34); checkScan("ld1_d0", 7'b0111001, 4'b0001);
    stepTo(38); checkScan("ld1_d1", 7'b1111001, 4'b0010);
    stepTo(42); checkScan("ld1_d2", 7'b0111111, 4'b0100);
    stepTo(46); checkScan("ld1_d3", 7'b0000000, 4'b1000);

    // Second offer while pending is held off until the commit
    stepTo(50); applyStimulus(1'b1, {5'h01, 5'h0B, 5'h0A, 5'h08});
    stepTo(51); applyStimulus(1'b0, 20'h0);
    stepTo(52); applyStimulus(1'b1, {5'h16, 5'h13, 5'h14, 5'h15});
    stepTo(53); checkOutput("hold_ready_e53", {7'b0, msg_ready}, 8'h00);
    stepTo(63); checkOutput("hold_ready_e63", {7'b0, msg_ready}, 8'h00);
    stepTo(64); checkOutput("hold_ready_e64", {7'b0, msg_ready}, 8'h01);
    stepTo(65); checkOutput("hold_ready_e65", {7'b0, msg_ready}, 8'h00);
    applyStimulus(1'b0, 20'h0);
    stepTo(66); checkScan("m2_d0", 7'b1111111, 4'b0001);
    stepTo(70); checkScan("m2_d1", 7'b1110111, 4'b0010);
    stepTo(74); checkScan("m2_d2", 7'b1111100, 4'b0100);
    stepTo(78); checkScan("m2_d3", 7'b0000110, 4'b1000);
    stepTo(82); checkScan("m3_d0", 7'b1110011, 4'b0001);
    stepTo(86); checkScan("m3_d1", 7'b1101101, 4'b0010);
    stepTo(90); checkScan("m3_d2", 7'b1010000, 4'b0100);
    stepTo(94); checkScan("m3_d3", 7'b1000000, 4'b1000);

    // Transfer on the frame_end edge commits one frame later
    stepTo(95); applyStimulus(1'b1, {5'h00, 5'h13, 5'h13, 5'h12});
    stepTo(96); checkOutput("fe_ready_e96", {7'b0, msg_ready}, 8'h00);
    applyStimulus(1'b0, 20'h0);
    stepTo(98);  checkScan("fe_old_d0", 7'b1110011, 4'b0001);
    stepTo(110); checkScan("fe_old_d3", 7'b1000000, 4'b1000);
    stepTo(112); checkOutput("fe_ready_e112", {7'b0, msg_ready}, 8'h01);
    stepTo(114); checkScan("m4_d0", 7'b1111001, 4'b0001);
    stepTo(118); checkScan("m4_d1", 7'b1010000, 4'b0010);
    stepTo(126); checkScan("m4_d3", 7'b0111111, 4'b1000);

    // Blink: frames 8-9 visible, frames 10-11 dark when the feature is built
    stepTo(127); blink = 1'b1;
    stepTo(130); checkScan("blink_f8", 7'b1111001, 4'b0001);
    stepTo(146); checkScan("blink_f9", 7'b1111001, 4'b0001);
    stepTo(162); checkScan("blink_f10_d0", 7'b1111001, EN_BLINK_D0);
    stepTo(174); checkScan("blink_f10_d3", 7'b0111111, EN_BLINK_D3);
    blink = 1'b0;
    stepTo(175); checkScan("blink_release", 7'b0111111, 4'b1000);

    // Reset mid-frame with a message pending
    applyStimulus(1'b1, {5'h08, 5'h08, 5'h08, 5'h08});
    stepTo(176); checkOutput("rst_pending", {7'b0, msg_ready}, 8'h00);
    applyStimulus(1'b0, 20'h0);
    #2;
    pulseReset("rst1");
    stepTo(2);  checkScan("post_rst_e2", 7'b0000000, 4'b0001);
    checkOutput("post_rst_ready", {7'b0, msg_ready}, 8'h01);
    stepTo(16); checkOutput("post_rst_fs", {7'b0, frame_start}, 8'h01);
    stepTo(18); checkScan("post_rst_f1", 7'b0000000, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_msg_scanner.md
Name: seg7_msg_scanner

Overview:
- Parametrised, time-multiplexed 7-segment message driver for the coffee-machine front panel.
- Holds an N-character message (status codes, error codes, counts) and scans it across N common-cathode digits, one digit per refresh slot.
- Message updates are double-buffered and take effect only at frame boundaries, so the display never tears.
- Supports anti-ghosting blanking and optional blinking.

Parameters:
- NUM_DIGITS, 4, digits scanned per frame (≥2).
- PRESCALE, 50000, clock cycles per digit slot (≥4).
- BLANK_CYCLES, 2, cycles at slot start with all digits off (< PRESCALE).
- BLINK_FRAMES, 64, frames per blink half-period (used only with SEG7_BLINK_EN).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- msg_data  in  5*NUM_DIGITS  character codes; digit i at bits [5i+4:5i]; digit 0 is leftmost
- msg_valid  in  1  new message offered
- msg_ready  out  1  shadow buffer free; transfer on msg_valid && msg_ready
- blink  in  1  request blinking of whole display
- seg  out  7  segment drive, active high; seg[0]=a … seg[6]=g
- digit_en  out  NUM_DIGITS  one-hot digit select, active high
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (async, reset_n=0):
  - Prescaler=0, digit index=0, active and shadow buffers = BLANK code.
  - pending=0, msg_ready=1, seg=0, digit_en=0, frame_start=0, blink phase=on, frame counter=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler==PRESCALE-1).
  - On tick, index increments; it wraps NUM_DIGITS-1→0.
- frame_end = tick && index==NUM_DIGITS-1.
- frame_start is registered: it is 1 in the cycle after frame_end.
- Handshake:
  - msg_ready = !pending.
  - On a transfer, msg_data is latched into the shadow buffer and pending is set.
  - On frame_end with pending=1, shadow is copied to active and pending is cleared. msg_ready is high again the next cycle.
  - A transfer in the same cycle as frame_end while pending=0 is latched to shadow. It commits at the following frame_end, not the current one.
  - msg_valid while msg_ready=0 is ignored; the data must be held by the source.
- Output stage (registered, 1-cycle latency from index/prescaler):
  - seg = decode(active[index]).
  - digit_en = one-hot(index), except forced 0 while prescaler < BLANK_CYCLES.
  - seg is valid throughout; only digit_en is blanked.
- Character decode, 5-bit code → {g..a}:
  - 0x00–0x0F: hex digits 0–F, standard patterns. Examples: 0=0111111, 1=0000110, 8=1111111, A=1110111, b=1111100.
  - 0x10 BLANK=0000000, 0x11 'C'=0111001, 0x12 'E'=1111001, 0x13 'r'=1010000, 0x14 'S'=1101101, 0x15 'P'=1110011, 0x16 '-'=1000000.
  - 0x17–0x1F: BLANK.
- Reset mid-scan: all state returns to reset values immediately. Any pending message is lost.

Optional Feature:
- SEG7_BLINK_EN defined:
  - A frame counter increments on frame_end and wraps at BLINK_FRAMES-1; at the wrap, blink phase toggles.
  - While blink=1 and phase=off, digit_en is forced to 0.
  - Deasserting blink shows the display on the next cycle; phase and counter keep running.
- Macro undefined: the blink port exists but is ignored. No counter or phase logic is built, and digit_en is never blink-gated.

Decomposition:
- Package seg7_pkg:
  - char_code_t (5-bit).
  - Code constants CH_BLANK, CH_C, CH_E, CH_R, CH_S, CH_P, CH_DASH.
  - Segment constants for each pattern.
  - A decode function.
- Sub-module seg7_char_decoder: combinational 5→7 decode, reused by other panel blocks.
- Scanner, buffers and handshake stay in the top module.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, BLINK_FRAMES=2):
- Reset release → seg=0, digit_en=0 during blank cycles; then digit_en steps 0001,0010,0100,1000 every 4 cycles with seg=0000000 (all BLANK).
- Load {0x11,0x12,0x00,0x10} ('C','E','0',blank) mid-frame → msg_ready low until frame_end. From the next frame: digit0 seg=0111001, digit1 1111001, digit2 0111111, digit3 0000000.
- Second msg_valid while pending → no transfer (msg_ready=0). Offer held → accepted the cycle after commit and shown one frame later.
- Transfer coinciding with frame_end (pending=0) → old message is displayed for one more full frame; the new one appears at the following frame.
- reset_n pulsed low mid-frame with message pending → outputs 0 immediately; after release, display is blank and msg_ready=1.
- SEG7_BLINK_EN, blink=1 → digit_en active for 2 frames, all-zero for 2 frames, repeating. blink=0 → scanning resumes next cycle. Without macro → blink has no effect.
